// File: rtl/pattern_pkg.sv
// Shared constants for the "EHSAN HOSSEINZADEH" pattern generator/decoder pair:
// pattern ROM, sync characters and the decoder state encoding.
package pattern_pkg;

    localparam int unsigned PAT_LEN = 18;
    localparam int unsigned POS_W   = 5;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [6:0]       char_t;

    localparam char_t PAT_ROM [PAT_LEN] = '{
        7'h45, 7'h48, 7'h53, 7'h41, 7'h4E, 7'h20, 7'h48, 7'h4F, 7'h53,
        7'h53, 7'h45, 7'h49, 7'h4E, 7'h5A, 7'h41, 7'h44, 7'h45, 7'h48
    };

    // "EHS" only ever appears at indices 0..2 of the repeating stream
    localparam char_t SYNC_E = 7'h45;
    localparam char_t SYNC_H = 7'h48;
    localparam char_t SYNC_S = 7'h53;

    typedef enum logic [1:0] {
        StHunt,
        StSawE,
        StSawEh,
        StLocked
    } state_e;

    function automatic pos_t next_pos(pos_t p);
        return (p == pos_t'(PAT_LEN - 1)) ? '0 : p + pos_t'(1);
    endfunction

endpackage

// File: rtl/name_char_rom.sv
// Combinational pattern ROM: position index to expected 7-bit ASCII character.
// Out-of-range indices return 0.
module name_char_rom
    import pattern_pkg::*;
(
    input  logic [POS_W-1:0] idx_i,
    output logic [6:0]       char_o
);

    always_comb begin
        char_o = '0;
        if (idx_i < pos_t'(PAT_LEN)) begin
            char_o = PAT_ROM[idx_i];
        end
    end

endmodule

// File: rtl/name_pattern_decoder.sv
// Receive-side pattern decoder: hunts for "EHS", then tracks the one-hot position.
// Optional feature: PATTERN_ERRCNT_EN builds the saturating err_count register.
module name_pattern_decoder
    import pattern_pkg::*;
#(
    parameter int unsigned MAX_MISS = 3
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               ascii_valid,
    input  logic [6:0]         ascii,
    output logic [0:PAT_LEN-1] Q,
    output logic               locked,
    output logic               err,
    output logic               frame_done,
    output logic [7:0]         err_count
);

    state_e     state_q, state_d;
    pos_t       pos_q, pos_d;
    logic [3:0] miss_q, miss_d;
    logic       err_q, err_d;
    logic       frame_done_q, frame_done_d;

    pos_t  pos_nxt;
    char_t exp_char;
    logic  match;
    logic  lock_lost;

    assign pos_nxt   = next_pos(pos_q);
    assign match     = (ascii == exp_char);
    assign lock_lost = ((miss_q + 4'd1) >= 4'(MAX_MISS));

    name_char_rom u_rom (
        .idx_i  (pos_nxt),
        .char_o (exp_char)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StHunt;
            pos_q        <= '0;
            miss_q       <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            miss_q       <= miss_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        miss_d  = miss_q;
        if (ascii_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (ascii == SYNC_E) state_d = StSawE;
                end
                StSawE: begin
                    if (ascii == SYNC_H)      state_d = StSawEh;
                    else if (ascii == SYNC_E) state_d = StSawE;
                    else                      state_d = StHunt;
                end
                StSawEh: begin
                    if (ascii == SYNC_S) begin
                        state_d = StLocked;
                        pos_d   = pos_t'(2);
                        miss_d  = '0;
                    end else if (ascii == SYNC_E) begin
                        state_d = StSawE;
                    end else begin
                        state_d = StHunt;
                    end
                end
                StLocked: begin
                    pos_d = pos_nxt;
                    if (match) begin
                        miss_d = '0;
                    end else if (lock_lost) begin
                        state_d = StHunt;
                        pos_d   = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + 4'd1;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_comb begin
        err_d        = ascii_valid && (state_q == StLocked) && !match;
        frame_done_d = ascii_valid && (state_q == StLocked) && match
                       && (pos_nxt == pos_t'(PAT_LEN - 1));
    end

    always_comb begin
        Q = '0;
        if (state_q == StLocked) Q[pos_q] = 1'b1;
    end

    assign locked     = (state_q == StLocked);
    assign err        = err_q;
    assign frame_done = frame_done_q;

`ifdef PATTERN_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end

    // Survives loss of lock; only reset clears it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) err_count_q <= '0;
        else        err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_name_pattern_decoder.sv
// Table-driven bench for name_pattern_decoder with hand-derived expected positions,
// plus a hand-written asynchronous mid-frame reset sequence.
module tb_name_pattern_decoder;

    localparam int N = 18;
    localparam string PAT = "EHSAN HOSSEINZADEH";

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ascii_valid = 1'b0;
    logic [6:0]   ascii = '0;
    logic [0:N-1] q;
    logic         locked;
    logic         err;
    logic         frame_done;
    logic [7:0]   err_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic       v;
        logic [6:0] ch;
        int         pos;
        logic       e;
        logic       fd;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    name_pattern_decoder #(.MAX_MISS(3)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .ascii_valid (ascii_valid),
        .ascii       (ascii),
        .Q           (q),
        .locked      (locked),
        .err         (err),
        .frame_done  (frame_done),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    function automatic int ecnt(int n);
`ifdef PATTERN_ERRCNT_EN
        return n;
`else
        return n & 0;
`endif
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(string name, int pos, logic e, logic fd, int cnt);
        logic [0:N-1] eq;
        eq = '0;
        if (pos >= 0) eq[pos] = 1'b1;
        check({name, " Q"}, int'(q), int'(eq));
        check({name, " locked"}, int'(locked), int'(pos >= 0));
        check({name, " err"}, int'(err), int'(e));
        check({name, " frame_done"}, int'(frame_done), int'(fd));
        check({name, " err_count"}, int'(err_count), cnt);
    endtask

    function automatic void add(string name, logic v, byte c, int pos, logic e, logic fd,
                                int cnt);
        vec_t r;
        r.name = name; r.v = v; r.ch = 7'(c); r.pos = pos;
        r.e = e; r.fd = fd; r.cnt = cnt;
        tbl.push_back(r);
    endfunction

    function automatic void add_hunt(string name, string s, int cnt);
        for (int i = 0; i < s.len(); i++) add(name, 1'b1, s[i], -1, 1'b0, 1'b0, cnt);
    endfunction

    function automatic void add_locked(string name, string s, int start, int cnt);
        for (int i = 0; i < s.len(); i++) begin
            int p;
            p = (start + i) % N;
            add(name, 1'b1, s[i], p, 1'b0, p == N - 1, cnt);
        end
    endfunction

    task automatic run_tbl();
        foreach (tbl[i]) begin
            @(negedge clk);
            ascii_valid = tbl[i].v;
            ascii       = tbl[i].ch;
            @(posedge clk);
            #1;
            check_outputs(tbl[i].name, tbl[i].pos, tbl[i].e, tbl[i].fd, tbl[i].cnt);
        end
        tbl.delete();
        @(negedge clk);
        ascii_valid = 1'b0;
    endtask

    task automatic do_reset(string name);
        @(negedge clk);
        rst_n       = 1'b0;
        ascii_valid = 1'b0;
        #1;
        check_outputs(name, -1, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset("reset0");

        // Two clean frames: lock on the first 'S', frame_done at positions 17 and 35
        for (int i = 0; i < 2 * N; i++) begin
            add("frames", 1'b1, PAT[i % N], (i < 2) ? -1 : i % N, 1'b0,
                (i % N) == N - 1, 0);
        end
        run_tbl();

        do_reset("reset1");

        add_hunt("xee", "XEEH", 0);
        add("lock_s", 1'b1, "S", 2, 1'b0, 1'b0, 0);
        add_locked("an", "AN", 3, 0);
        add("bad_space", 1'b1, "Q", 5, 1'b1, 1'b0, ecnt(1));
        add_locked("resume", "HOSSEINZADEH", 6, ecnt(1));
        add("miss1", 1'b1, "X", 0, 1'b1, 1'b0, ecnt(2));
        add("miss2", 1'b1, "X", 1, 1'b1, 1'b0, ecnt(3));
        add("miss3", 1'b1, "X", -1, 1'b1, 1'b0, ecnt(4));
        add_hunt("relock_eh", "EH", ecnt(4));
        add("relock_s", 1'b1, "S", 2, 1'b0, 1'b0, ecnt(4));
        add_locked("an2", "AN", 3, ecnt(4));
        for (int p = 5; p < N; p++) begin
            add("toggle_v", 1'b1, PAT[p], p, 1'b0, p == N - 1, ecnt(4));
            add("toggle_idle", 1'b0, "X", p, 1'b0, 1'b0, ecnt(4));
        end
        add_locked("wrap", "EH", 0, ecnt(4));
        run_tbl();

        do_reset("reset2");

        add_hunt("pre_eh", "EH", 0);
        add_locked("to_pos10", "SAN HOSSE", 2, 0);
        run_tbl();

        // Async reset between clock edges must clear outputs without a clock
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", -1, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        add_hunt("rehunt", "INZADEHEH", 0);
        add("rehunt_s", 1'b1, "S", 2, 1'b0, 1'b0, 0);
        run_tbl();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
